// File: rtl/dtfag_mul_sel_pipe.sv
// -----------------------------------------------------------------------------
// dtfag_mul_sel_pipe
// Registered multiplier-A operand selector for the DTFAG. It takes LANES
// twiddle lanes from the R16 stage and maps them per beat with one of four
// modes: zero, pass, lane-reversed (IFFT reordering) or constant one. The
// selected bus sits behind a single valid/ready register stage, so the DTFAG
// can stall against the multiplier array. A counter tracks accepted beats.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   in_valid       upstream beat valid
//   in_ready       block can take a beat this cycle (combinational)
//   mul_sel        beat mode: 0 zero, 1 pass, 2 reverse, 3 one
//   r16_in         flattened input lanes, lane i = [i*D_WIDTH +: D_WIDTH]
//   out_valid      mul_a_out holds a valid beat
//   out_ready      downstream accepts the beat
//   mul_a_out      flattened selected operands, same lane packing as r16_in
//   beat_cnt       accepted beats, modulo 2^CNT_W
//
// Optional feature, enabled by defining DTFAG_MUL_SEL_STAT_EN:
//   stat_clr       synchronous clear of zero_beat_cnt (wins over increment)
//   zero_beat_cnt  saturating count of accepted mode-0 beats
// -----------------------------------------------------------------------------
module dtfag_mul_sel_pipe #(
   parameter int          D_WIDTH = 64,
   parameter int          LANES   = 16,
   parameter int          CNT_W   = 8,
   parameter logic [63:0] P_ONE   = 64'd1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 mul_sel,
   input  logic [LANES*D_WIDTH-1:0]   r16_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*D_WIDTH-1:0]   mul_a_out,
   output logic [CNT_W-1:0]           beat_cnt
`ifdef DTFAG_MUL_SEL_STAT_EN
   ,
   input  logic                       stat_clr,
   output logic [15:0]                zero_beat_cnt
`endif
);

   typedef enum logic [1:0] {
      MODE_ZERO = 2'd0,
      MODE_PASS = 2'd1,
      MODE_REV  = 2'd2,
      MODE_ONE  = 2'd3
   } mode_e;

   // Constant one, truncated or zero-extended to the lane width.
   localparam logic [D_WIDTH-1:0] ONE_LANE = D_WIDTH'(P_ONE);

   logic                       accept;
   logic [LANES*D_WIDTH-1:0]   mapped;

   // A beat can enter when the output register is empty or draining now.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      // NOTE: default assignment first so every path drives mapped; without
      // it a missing case arm would infer a latch.
      mapped = '0;
      for (int i = 0; i < LANES; i++) begin
         unique case (mode_e'(mul_sel))
            MODE_ZERO: mapped[i*D_WIDTH +: D_WIDTH] = '0;
            MODE_PASS: mapped[i*D_WIDTH +: D_WIDTH] = r16_in[i*D_WIDTH +: D_WIDTH];
            MODE_REV:  mapped[i*D_WIDTH +: D_WIDTH] = r16_in[(LANES-1-i)*D_WIDTH +: D_WIDTH];
            MODE_ONE:  mapped[i*D_WIDTH +: D_WIDTH] = ONE_LANE;
            default:   mapped[i*D_WIDTH +: D_WIDTH] = '0;
         endcase
      end
   end

   // Output register stage. The data register only loads on accept, so
   // r16_in/mul_sel on idle or stalled cycles (including X) never reach it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         mul_a_out <= '0;
         beat_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update based
         // on pre-edge values, independent of statement order.
         if (accept) begin
            mul_a_out <= mapped;
            out_valid <= 1'b1;
            beat_cnt  <= beat_cnt + CNT_W'(1);
         end else if (out_ready) begin
            // Handshake without a replacement beat: drop valid, keep data.
            out_valid <= 1'b0;
         end
      end
   end

`ifdef DTFAG_MUL_SEL_STAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_beat_cnt <= '0;
      end else if (stat_clr) begin
         zero_beat_cnt <= '0;
      end else if (accept && (mode_e'(mul_sel) == MODE_ZERO)
                   && (zero_beat_cnt != 16'hFFFF)) begin
         zero_beat_cnt <= zero_beat_cnt + 16'd1;
      end
   end
`endif

endmodule
